// File: rtl/sa_cache_pkg.sv
// Shared types and helpers for the set-associative data cache.
package sa_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_WRITE
  } state_t;

  // Access-size encoding used by the memory stage.
  localparam logic [2:0] DATA_ADDR_MODE_B  = 3'd0;
  localparam logic [2:0] DATA_ADDR_MODE_BU = 3'd1;
  localparam logic [2:0] DATA_ADDR_MODE_H  = 3'd2;
  localparam logic [2:0] DATA_ADDR_MODE_HU = 3'd3;
  localparam logic [2:0] DATA_ADDR_MODE_W  = 3'd4;

  // Tags are stored zero-extended to a fixed width so one struct serves any geometry.
  localparam int TAG_W_MAX = 32;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [3:0][7:0]      lane;
  } line_t;

  // Byte lanes touched by a store of the given size at the given offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] mode, input logic [1:0] offset);
    case (mode)
      DATA_ADDR_MODE_B, DATA_ADDR_MODE_BU: lane_mask = 4'b0001 << offset;
      DATA_ADDR_MODE_H, DATA_ADDR_MODE_HU: lane_mask = offset[1] ? 4'b1100 : 4'b0011;
      default:                             lane_mask = 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data across the word so every lane sees its bytes.
  function automatic logic [31:0] store_align(input logic [2:0] mode, input logic [31:0] wdata);
    case (mode)
      DATA_ADDR_MODE_B, DATA_ADDR_MODE_BU: store_align = {4{wdata[7:0]}};
      DATA_ADDR_MODE_H, DATA_ADDR_MODE_HU: store_align = {2{wdata[15:0]}};
      default:                             store_align = wdata;
    endcase
  endfunction

endpackage

// File: rtl/sa_cache_way.sv
// One way of the cache: per-set line storage and tag compare for the addressed set.
module sa_cache_way
  import sa_cache_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int IDX_W = 3,
  parameter int TAG_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] index,
  input  logic [TAG_W-1:0] tag,
  input  logic             install_en,
  input  logic [31:0]      install_data,
  input  logic             store_en,
  input  logic [3:0]       store_mask,
  input  logic [31:0]      store_data,
  output logic             valid,
  output logic             match,
  output logic [31:0]      rdata
);

  line_t                lines [SETS];
  logic [TAG_W_MAX-1:0] tag_ext;

  assign tag_ext = TAG_W_MAX'(tag);
  assign valid   = lines[index].valid;
  assign match   = lines[index].valid && (lines[index].tag == tag_ext);
  assign rdata   = lines[index].lane;

  // Line storage: refill installs a whole line, a store hit updates selected lanes.
  // NOTE: only the valid bits are reset; tag and data are don't-care while invalid,
  // so clearing them would just add reset fan-out to the whole array.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) lines[i].valid <= 1'b0;
    end else if (install_en) begin
      lines[index].valid <= 1'b1;
      lines[index].tag   <= tag_ext;
      lines[index].lane  <= install_data;
    end else if (store_en) begin
      for (int b = 0; b < 4; b++)
        if (store_mask[b]) lines[index].lane[b] <= store_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/sa_cache.sv
// N-way set-associative write-through, write-no-allocate data cache.
// Optional hit/miss counters are built when SA_CACHE_STATS_EN is defined.
module sa_cache
  import sa_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 8,
  parameter int WAYS       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [2:0]            addr_mode,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  hit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_addr_mode,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

  state_t                state, state_next;
  logic [IDX_W-1:0]      index;
  logic [TAG_W-1:0]      tag;
  logic [WAYS-1:0]       way_valid, way_match;
  logic [DATA_WIDTH-1:0] way_rdata [WAYS];
  logic [DATA_WIDTH-1:0] hit_data;
  logic [WAY_W-1:0]      victim_ptr [SETS];
  logic [WAY_W-1:0]      victim_way;
  logic                  victim_from_ptr;
  logic                  any_match, store_en, install_en;
  logic [3:0]            store_mask;
  logic [DATA_WIDTH-1:0] store_data;

  assign index      = cpu_addr[2 +: IDX_W];
  assign tag        = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign store_mask = lane_mask(addr_mode, cpu_addr[1:0]);
  assign store_data = store_align(addr_mode, cpu_wdata);

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    sa_cache_way #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_way (
      .clk          (clk),
      .rst          (rst),
      .index        (index),
      .tag          (tag),
      .install_en   (install_en && (victim_way == WAY_W'(w))),
      .install_data (mem_rdata),
      .store_en     (store_en && way_match[w]),
      .store_mask   (store_mask),
      .store_data   (store_data),
      .valid        (way_valid[w]),
      .match        (way_match[w]),
      .rdata        (way_rdata[w])
    );
  end

  // Hit-way data select and refill victim choice (lowest invalid way, else pointer).
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit_data        = '0;
    victim_way      = victim_ptr[index];
    victim_from_ptr = 1'b1;
    for (int w = 0; w < WAYS; w++)
      if (way_match[w]) hit_data = hit_data | way_rdata[w];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!way_valid[w]) begin
        victim_way      = WAY_W'(w);
        victim_from_ptr = 1'b0;
      end
  end

  assign any_match = cpu_req && !rst && (state == ST_IDLE) && (|way_match);
  assign hit       = any_match;

  // Next-state and core-side handshake; reset masks everything.
  always_comb begin
    state_next = state;
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    store_en   = 1'b0;
    install_en = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: if (cpu_req) begin
          if (cpu_we) begin
            state_next = ST_WRITE;
            store_en   = any_match;
          end else if (any_match) begin
            cpu_ready = 1'b1;
            cpu_rdata = hit_data;
          end else begin
            state_next = ST_REFILL;
          end
        end
        ST_REFILL: if (mem_ack) begin
          install_en = 1'b1;
          cpu_ready  = 1'b1;
          cpu_rdata  = mem_rdata;
          state_next = ST_IDLE;
        end
        ST_WRITE: if (mem_ack) begin
          cpu_ready  = 1'b1;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Memory-side request is a pure function of the state and the held core inputs.
  assign mem_req       = (state != ST_IDLE);
  assign mem_we        = (state == ST_WRITE);
  assign mem_addr      = (state == ST_WRITE)  ? cpu_addr :
                         (state == ST_REFILL) ? {cpu_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wdata     = (state == ST_WRITE) ? cpu_wdata : '0;
  assign mem_addr_mode = (state == ST_WRITE) ? addr_mode : DATA_ADDR_MODE_W;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Round-robin victim pointers advance only when a full set forced their use.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) victim_ptr[s] <= '0;
    end else if (install_en && victim_from_ptr) begin
      victim_ptr[index] <= (WAYS == 1) ? '0 : victim_ptr[index] + 1'b1;
    end
  end

`ifdef SA_CACHE_STATS_EN
  // Load hits completed in IDLE and refill completions, both wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (any_match && !cpu_we) hit_count  <= hit_count + 32'd1;
      if (install_en)           miss_count <= miss_count + 32'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_sa_cache.sv
// Directed bench for sa_cache (SETS=8, WAYS=2, 3-cycle memory latency).
module tb_sa_cache;
  import sa_cache_pkg::*;

  localparam int LAT = 3;
`ifdef SA_CACHE_STATS_EN
  localparam logic [31:0] EXP_HITS = 32'd2;
  localparam logic [31:0] EXP_MISS = 32'd1;
`else
  localparam logic [31:0] EXP_HITS = 32'd0;
  localparam logic [31:0] EXP_MISS = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst, cpu_req, cpu_we, mem_ack;
  logic [2:0]  addr_mode, mem_addr_mode;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ready, hit, mem_req, mem_we;
  logic [31:0] hit_count, miss_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sa_cache #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SETS(8), .WAYS(2)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .addr_mode(addr_mode),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .hit(hit), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_mode(mem_addr_mode),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One core access; misses and stores are served by a LAT-cycle memory.
  task automatic access(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_hit,
                        input logic [31:0] exp_rdata, input string tag);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; addr_mode = mode; cpu_addr = addr; cpu_wdata = wdata;
    #1;
    check({tag, ".hit"}, 32'(hit), 32'(exp_hit));
    if (!we && exp_hit) begin
      check({tag, ".ready"}, 32'(cpu_ready), 32'd1);
      check({tag, ".rdata"}, cpu_rdata, exp_rdata);
    end else begin
      check({tag, ".ready0"}, 32'(cpu_ready), 32'd0);
      for (int c = 1; c <= LAT; c++) begin
        @(negedge clk);
        check({tag, ".mem_req"}, 32'(mem_req), 32'd1);
        if (c == 1) begin
          check({tag, ".mem_we"}, 32'(mem_we), 32'(we));
          check({tag, ".mem_addr"}, mem_addr, we ? addr : {addr[31:2], 2'b00});
          check({tag, ".mem_mode"}, 32'(mem_addr_mode), 32'(we ? mode : DATA_ADDR_MODE_W));
          if (we) check({tag, ".mem_wdata"}, mem_wdata, wdata);
        end
        if (c == LAT) begin
          mem_ack = 1'b1;
          mem_rdata = exp_rdata;
          #1;
          check({tag, ".done"}, 32'(cpu_ready), 32'd1);
          if (!we) check({tag, ".fill_rdata"}, cpu_rdata, exp_rdata);
        end else begin
          #1;
          check({tag, ".wait"}, 32'(cpu_ready), 32'd0);
        end
      end
    end
    @(negedge clk);
    cpu_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    #1;
    check({tag, ".idle_req"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; addr_mode = DATA_ADDR_MODE_W;
    cpu_addr = 32'h100; cpu_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

    // Reset state, with a request held alongside reset.
    repeat (2) @(negedge clk);
    #1;
    check("rst.hit", 32'(hit), 32'd0);
    check("rst.ready", 32'(cpu_ready), 32'd0);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.rdata", cpu_rdata, 32'd0);
    check("rst.hits", hit_count, 32'd0);
    check("rst.misses", miss_count, 32'd0);
    cpu_req = 1'b0;
    rst = 1'b0;

    // Miss then zero-wait hit.
    access(1'b0, DATA_ADDR_MODE_W, 32'h100, '0, 1'b0, 32'hDEADBEEF, "ld100_miss");
    access(1'b0, DATA_ADDR_MODE_W, 32'h100, '0, 1'b1, 32'hDEADBEEF, "ld100_hit");

    // Byte and half stores hit and update only their lanes; word store miss does not allocate.
    access(1'b1, DATA_ADDR_MODE_B, 32'h102, 32'h55, 1'b1, '0, "stb102");
    access(1'b0, DATA_ADDR_MODE_W, 32'h100, '0, 1'b1, 32'hDE55BEEF, "ld100_b");
    access(1'b1, DATA_ADDR_MODE_H, 32'h102, 32'hABCD, 1'b1, '0, "sth102");
    access(1'b0, DATA_ADDR_MODE_W, 32'h100, '0, 1'b1, 32'hABCDBEEF, "ld100_h");
    access(1'b1, DATA_ADDR_MODE_W, 32'h300, 32'h12345678, 1'b0, '0, "stw300");
    access(1'b0, DATA_ADDR_MODE_W, 32'h300, '0, 1'b0, 32'h12345678, "ld300_miss");

    // Set-0 conflicts: third line evicts way0, pointer moves to way1.
    reset_dut();
    access(1'b0, DATA_ADDR_MODE_W, 32'h000, '0, 1'b0, 32'h0000AAAA, "c000");
    access(1'b0, DATA_ADDR_MODE_W, 32'h020, '0, 1'b0, 32'h0020BBBB, "c020");
    access(1'b0, DATA_ADDR_MODE_W, 32'h040, '0, 1'b0, 32'h0040CCCC, "c040");
    access(1'b0, DATA_ADDR_MODE_W, 32'h020, '0, 1'b1, 32'h0020BBBB, "c020_hit");
    access(1'b0, DATA_ADDR_MODE_W, 32'h040, '0, 1'b1, 32'h0040CCCC, "c040_hit");
    access(1'b0, DATA_ADDR_MODE_W, 32'h000, '0, 1'b0, 32'h0000AAAA, "c000_miss");
    // 0x000 replaced way1 (0x020), so 0x040 must still be resident.
    access(1'b0, DATA_ADDR_MODE_W, 32'h040, '0, 1'b1, 32'h0040CCCC, "c040_kept");

    // Reset in the second refill cycle abandons the transaction.
    reset_dut();
    access(1'b0, DATA_ADDR_MODE_W, 32'h100, '0, 1'b0, 32'hDEADBEEF, "r100");
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; addr_mode = DATA_ADDR_MODE_W; cpu_addr = 32'h200;
    @(negedge clk);
    #1;
    check("rr.req_c1", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rr.ready_in_rst", 32'(cpu_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0; cpu_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    #1;
    check("rr.req_after_rst", 32'(mem_req), 32'd0);
    check("rr.late_ack_ready", 32'(cpu_ready), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    check("rr.req_idle", 32'(mem_req), 32'd0);
    access(1'b0, DATA_ADDR_MODE_W, 32'h100, '0, 1'b0, 32'hDEADBEEF, "rr100_miss");
    access(1'b0, DATA_ADDR_MODE_W, 32'h200, '0, 1'b0, 32'h22220000, "rr200_miss");

    // Statistics: miss, hit, hit, store.
    reset_dut();
    access(1'b0, DATA_ADDR_MODE_W, 32'h100, '0, 1'b0, 32'hDEADBEEF, "s_miss");
    access(1'b0, DATA_ADDR_MODE_W, 32'h100, '0, 1'b1, 32'hDEADBEEF, "s_hit1");
    access(1'b0, DATA_ADDR_MODE_W, 32'h100, '0, 1'b1, 32'hDEADBEEF, "s_hit2");
    access(1'b1, DATA_ADDR_MODE_W, 32'h100, 32'h01020304, 1'b1, '0, "s_store");
    check("stats.hits", hit_count, EXP_HITS);
    check("stats.misses", miss_count, EXP_MISS);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
